rr_arbiter_n: RTL and testbench
===============================

Name: rr_arbiter_n

Overview:
- Parametrised N-input round-robin arbiter with packet lock. It is the successor to the 2-input output-port arbitrator used in the ring router.
- It grants one of N requesters access to a single output buffer. When LOCK_EN=1 it holds the grant for a multi-flit packet until that requester signals its last flit.
- Used for router output ports when the ring grows to more input channels and carries multi-flit packets.

Parameters:
- N, 4, number of requesters; legal range ≥2.
- IDX_W, $clog2(N), width of the winner index; derived, do not override.
- INIT_PTR, 0, priority pointer value after reset; must be < N.
- LOCK_EN, 1, 1 = hold grant until last flit of packet; 0 = every grant is single-beat.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  arbiter active this cycle (odd/even phase enable)
- output_ready  in  1  target output buffer can accept a flit this cycle
- req  in  N  per-requester request
- last  in  N  per-requester flag: the current flit is the final flit of its packet
- win  out  N  one-hot grant, combinational, valid in the same cycle
- win_idx  out  IDX_W  index of the granted requester; 0 when win_valid=0
- win_valid  out  1  OR of win
- locked  out  1  registered; arbiter is mid-packet

Behaviour:
- A "beat" is any cycle with en && output_ready && win_valid. Grants are only issued when en && output_ready; otherwise win=0 and all state holds.
- Registered state:
  - ptr (IDX_W bits)
  - state IDLE/LOCKED (locked=1 in LOCKED)
  - owner (IDX_W bits)
- Reset (reset_n low, asynchronous):
  - ptr=INIT_PTR, state=IDLE, owner=0.
  - win, win_idx and win_valid are forced 0 while reset_n is low.
- IDLE:
  - Winner w is the first i with req[i]=1 when scanning cyclically ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - win[w]=1 in the same cycle; zero-latency grant.
  - On the beat, if LOCK_EN=0 or last[w]=1: ptr <= (w+1) mod N, and state stays IDLE.
  - On the beat, if LOCK_EN=1 and last[w]=0: owner <= w, state <= LOCKED, and ptr is unchanged.
  - No requests: win=0, nothing changes.
- LOCKED:
  - Only the owner can win. win[owner]=req[owner] && en && output_ready; all other requests are masked.
  - On a beat with last[owner]=1: ptr <= (owner+1) mod N, state <= IDLE.
  - If req[owner] deasserts, the arbiter stays LOCKED with no grant and waits. It never times out.
  - Stalls (output_ready=0 or en=0) hold both state and owner.
- Pointer update happens only on packet completion, including when there is no contention. This generalises the 2-input flip and guarantees each requester waits at most N-1 packets.
- Wrap: the pointer increment is computed modulo N. For non-power-of-2 N, index N-1 wraps to 0 and never reaches N.
- Simultaneous:
  - All requesters asserting in IDLE → grant goes to the one at ptr.
  - A single-flit packet (last=1 on its first beat) never enters LOCKED.
- Reset asserted mid-packet → immediate return to IDLE with ptr=INIT_PTR. Any partial packet is the requester's concern.
- last[i] is ignored unless i is currently winning.

Test Plan:
- Reset check, N=4, INIT_PTR=0: hold reset_n low with req=4'b1111 → win=0, locked=0. Release; req=4'b1111, last=4'b1111, en=output_ready=1 for 4 cycles → win sequence 0001, 0010, 0100, 1000, then wraps to 0001.
- Sparse requests, N=4: req=4'b1010, all last=1 → alternating grants 0010, 1000, 0010. With req=4'b0100 alone → win=0100 every beat, and ptr then points to 3.
- Packet lock, LOCK_EN=1: req=4'b0011, last[0]=0 for 2 beats then 1 → win=0001 for 3 beats with locked=1 after the first beat; req[1] is masked throughout; the next grant is 0010 and locked=0.
- Stalls: during LOCKED, drop output_ready for 2 cycles and drop en for 1 cycle → win=0, locked stays 1, owner unchanged. Resume → same owner is granted.
- Owner drops request mid-packet: req[owner]=0 for 3 cycles while others request → win=0 throughout, state stays LOCKED.
- Non-power-of-2 and reset mid-packet: with N=3, all requesting, all last=1 → grants cycle through idx 0, 1, 2, 0 and win_idx never reaches 3. Assert reset_n low asynchronously mid-packet → locked=0 immediately and ptr=INIT_PTR.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// N-input round-robin arbiter with optional packet lock for a router output port.
// Latency: zero-cycle grant (win/win_idx/win_valid are combinational from req/en/output_ready).
// Backpressure: en=0 or output_ready=0 suppresses every grant and freezes ptr/state/owner.
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   en                 arbiter active this cycle (phase enable)
//   output_ready       downstream buffer can take a flit this cycle
//   req[N], last[N]    per-requester request and end-of-packet flag
//   win[N], win_idx    one-hot grant and its index (index is 0 when nothing is granted)
//   win_valid          any grant this cycle
//   locked             registered: a multi-flit packet is in progress
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int INIT_PTR = 0,
    parameter bit LOCK_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             output_ready,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid,
    output logic             locked
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_LOCKED = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] INIT_IDX  = IDX_W'(INIT_PTR);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [0:0]       r_state;

    logic             w_go;
    logic             w_hit;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_scan;

    // Modulo-N increment; explicit wrap so non-power-of-2 N never produces index N.
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Candidate selection. In LOCKED only the owner is eligible; in IDLE the
    // first requester found scanning cyclically from r_ptr wins.
    always_comb begin
        w_go   = reset_n && en && output_ready;
        w_hit  = 1'b0;
        w_sel  = '0;
        w_scan = r_ptr;
        if (r_state == ST_LOCKED) begin
            w_hit = req[r_owner];
            w_sel = r_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!w_hit && req[w_scan]) begin
                    w_hit = 1'b1;
                    w_sel = w_scan;
                end
                w_scan = f_next(w_scan);
            end
        end
    end

    // Reset is folded into w_go so outputs are forced low while reset_n is low.
    always_comb begin
        win       = '0;
        win_valid = w_go && w_hit;
        win_idx   = win_valid ? w_sel : '0;
        if (win_valid) begin
            win[w_sel] = 1'b1;
        end
    end

    assign locked = (r_state == ST_LOCKED);

    // State only moves on a beat; win_valid already implies en && output_ready.
    // The pointer advances on packet completion only, so an uncontended
    // multi-flit packet still rotates priority once, not once per flit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= INIT_IDX;
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else if (win_valid) begin
            if (r_state == ST_IDLE) begin
                if (!LOCK_EN || last[w_sel]) begin
                    r_ptr <= f_next(w_sel);
                end else begin
                    r_owner <= w_sel;
                    r_state <= ST_LOCKED;
                end
            end else if (last[r_owner]) begin
                r_ptr   <= f_next(r_owner);
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

    logic clk = 1'b0;
    logic rst_n, en, ordy;

    logic [3:0] req4, last4, win4;
    logic [1:0] idx4;
    logic       vld4, lk4;

    logic [2:0] req3, last3, win3;
    logic [1:0] idx3;
    logic       vld3, lk3;

    logic [4:0] req5, last5, win5;
    logic [2:0] idx5;
    logic       vld5, lk5;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance: 0 -> N=4 lock, 1 -> N=3 lock, 2 -> N=5 no lock
    int NN[3]   = '{4, 3, 5};
    int INIT[3] = '{0, 0, 2};
    bit LEN[3]  = '{1'b1, 1'b1, 1'b0};
    int m_ptr[3];
    int m_own[3];
    bit m_lk[3];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .INIT_PTR(0), .LOCK_EN(1'b1)) u4 (
        .clk(clk), .reset_n(rst_n), .en(en), .output_ready(ordy),
        .req(req4), .last(last4), .win(win4), .win_idx(idx4),
        .win_valid(vld4), .locked(lk4)
    );

    rr_arbiter_n #(.N(3), .INIT_PTR(0), .LOCK_EN(1'b1)) u3 (
        .clk(clk), .reset_n(rst_n), .en(en), .output_ready(ordy),
        .req(req3), .last(last3), .win(win3), .win_idx(idx3),
        .win_valid(vld3), .locked(lk3)
    );

    rr_arbiter_n #(.N(5), .INIT_PTR(2), .LOCK_EN(1'b0)) u5 (
        .clk(clk), .reset_n(rst_n), .en(en), .output_ready(ordy),
        .req(req5), .last(last5), .win(win5), .win_idx(idx5),
        .win_valid(vld5), .locked(lk5)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = INIT[i];
            m_lk[i]  = 1'b0;
            m_own[i] = 0;
        end
    endtask

    // Winner by rule: owner-only when locked, else first requester cyclically from ptr.
    function automatic int exp_winner(input int n, input int ptr, input bit lk, input int own,
                                      input logic [7:0] rq, input bit go);
        if (!go) return -1;
        if (lk) return rq[own] ? own : -1;
        for (int k = 0; k < n; k++) begin
            if (rq[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic chk_out(input string tag, input logic [7:0] w_act, input logic [7:0] i_act,
                           input logic v_act, input logic l_act, input int w, input bit mlk);
        chk({tag, ".win"},    32'(w_act), (w < 0) ? 32'd0 : (32'd1 << w));
        chk({tag, ".idx"},    32'(i_act), (w < 0) ? 32'd0 : 32'(w));
        chk({tag, ".valid"},  32'(v_act), 32'(w >= 0));
        chk({tag, ".locked"}, 32'(l_act), 32'(mlk));
    endtask

    // One clock: check outputs at negedge against the model, then advance model at posedge.
    task automatic cyc(input logic [3:0] exp4, input bit use_exp);
        int         w[3];
        logic [7:0] rq[3];
        logic [7:0] ls[3];
        bit         go;
        @(negedge clk);
        go    = rst_n && en && ordy;
        rq[0] = {4'b0, req4};  ls[0] = {4'b0, last4};
        rq[1] = {5'b0, req3};  ls[1] = {5'b0, last3};
        rq[2] = {3'b0, req5};  ls[2] = {3'b0, last5};
        for (int i = 0; i < 3; i++) begin
            w[i] = exp_winner(NN[i], m_ptr[i], m_lk[i], m_own[i], rq[i], go);
        end
        chk_out("u4", {4'b0, win4}, {6'b0, idx4}, vld4, lk4, w[0], m_lk[0]);
        chk_out("u3", {5'b0, win3}, {6'b0, idx3}, vld3, lk3, w[1], m_lk[1]);
        chk_out("u5", {3'b0, win5}, {5'b0, idx5}, vld5, lk5, w[2], m_lk[2]);
        chk("u3.idx_range", 32'(idx3 < 2'd3), 32'd1);
        if (use_exp) chk("u4.directed_win", 32'(win4), 32'(exp4));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w[i] >= 0) begin
                    if (!m_lk[i]) begin
                        if (!LEN[i] || ls[i][w[i]]) begin
                            m_ptr[i] = (w[i] + 1) % NN[i];
                        end else begin
                            m_own[i] = w[i];
                            m_lk[i]  = 1'b1;
                        end
                    end else if (ls[i][m_own[i]]) begin
                        m_ptr[i] = (m_own[i] + 1) % NN[i];
                        m_lk[i]  = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        ordy  = 1'b1;
        req4  = 4'b1111; last4 = 4'b1111;
        req3  = 3'b111;  last3 = 3'b111;
        req5  = 5'b11111; last5 = 5'b00000;

        // Reset holds outputs low even with every requester active.
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);

        // Full rotation with single-flit packets, then wrap.
        rst_n = 1'b1;
        cyc(4'b0001, 1'b1);
        cyc(4'b0010, 1'b1);
        cyc(4'b0100, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b0001, 1'b1);

        // Sparse requests alternate; lone requester then leaves ptr at 3.
        req4 = 4'b1010;
        cyc(4'b0010, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b0010, 1'b1);
        req4 = 4'b0100;
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        req4 = 4'b1111;
        cyc(4'b1000, 1'b1);

        // Packet lock: requester 0 holds for three flits, requester 1 masked.
        req4 = 4'b0011; last4 = 4'b0000;
        cyc(4'b0001, 1'b1);
        chk("lock.locked_after_first", 32'(lk4), 32'd1);
        cyc(4'b0001, 1'b1);
        last4 = 4'b0001;
        cyc(4'b0001, 1'b1);
        last4 = 4'b1111;
        cyc(4'b0010, 1'b1);

        // Stalls during a locked packet owned by requester 2.
        req4 = 4'b1100; last4 = 4'b0000;
        cyc(4'b0100, 1'b1);
        ordy = 1'b0;
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        ordy = 1'b1; en = 1'b0;
        cyc(4'b0000, 1'b1);
        en = 1'b1;
        cyc(4'b0100, 1'b1);
        chk("stall.still_locked", 32'(lk4), 32'd1);

        // Owner drops its request: everyone else stays masked.
        req4 = 4'b1011;
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        chk("drop.still_locked", 32'(lk4), 32'd1);
        req4 = 4'b0100; last4 = 4'b0100;
        cyc(4'b0100, 1'b1);

        // Asynchronous reset in the middle of packets on u4 and u3.
        req4 = 4'b0001; last4 = 4'b0000;
        last3 = 3'b000;
        cyc(4'b0001, 1'b1);
        chk("async.pre_lk4", 32'(lk4), 32'd1);
        chk("async.pre_lk3", 32'(lk3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async.lk4", 32'(lk4), 32'd0);
        chk("async.lk3", 32'(lk3), 32'd0);
        chk("async.win3", 32'(win3), 32'd0);
        chk("async.win4", 32'(win4), 32'd0);
        cyc(4'b0000, 1'b1);
        rst_n = 1'b1;
        req4 = 4'b1111; last4 = 4'b1111;
        req3 = 3'b111;  last3 = 3'b111;
        cyc(4'b0001, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            en    = ($urandom_range(0, 9) != 0);
            ordy  = ($urandom_range(0, 9) < 8);
            req4  = 4'($urandom);
            last4 = 4'($urandom);
            req3  = 3'($urandom);
            last3 = 3'($urandom);
            req5  = 5'($urandom);
            last5 = 5'($urandom);
            cyc(4'b0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
